// File: rtl/y_result_writer.sv
// Finished-row writer: converts FloPoCo doubles to IEEE-754, buffers them and
// issues one 8-byte write per row to the memory controller.
module y_result_writer #(
    parameter int          FIFO_DEPTH = 32,
    parameter int          SKID       = 16,
    parameter logic [2:0]  WR_CMD     = 3'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [47:0] y_base,
    input  logic [31:0] row_count,
    input  logic        push_to_y,
    input  logic [65:0] v_to_y,
    output logic        stall_out,
    output logic        mc_rq_vld,
    output logic [2:0]  mc_rq_cmd,
    output logic [47:0] mc_rq_vadr,
    output logic [63:0] mc_rq_data,
    input  logic        mc_rq_stall,
    output logic        busy,
    output logic        done,
    output logic        overflow_err
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [63:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   occ, occ_next;
    logic [31:0]   count_q, issued_q;
    logic [47:0]   ld_addr;
    logic          rq_vld;
    logic [47:0]   rq_vadr;
    logic [63:0]   rq_data;
    logic          ovf_q, stall_q;

    logic run, issue, term, load, pop, accept, drop;
    logic [63:0] conv;

    function automatic logic [63:0] flopoco_to_ieee(input logic [65:0] v);
        case (v[65:64])
            2'b00:   return {v[63], 63'b0};
            2'b01:   return v[63:0];
            2'b10:   return {v[63], 11'h7FF, 52'b0};
            default: return 64'h7FF8_0000_0000_0000;
        endcase
    endfunction

    // The final issue of a run does not reload the output register, so DONE
    // is entered with no request still held.
    always_comb begin
        run      = (state == S_RUN);
        issue    = rq_vld & ~mc_rq_stall;
        term     = run & issue & ((issued_q + 32'd1) == count_q);
        load     = run & (~rq_vld | issue) & ~term;
        pop      = load & (occ != '0);
        accept   = push_to_y & run & ((occ != (AW+1)'(FIFO_DEPTH)) | pop);
        drop     = push_to_y & ~accept;
        occ_next = occ + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};
        conv     = flopoco_to_ieee(v_to_y);
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= conv;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            count_q  <= '0;
            issued_q <= '0;
            ld_addr  <= '0;
            rq_vld   <= 1'b0;
            rq_vadr  <= '0;
            rq_data  <= '0;
            ovf_q    <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            stall_q <= (occ_next >= (AW+1)'(FIFO_DEPTH - SKID));
            occ     <= occ_next;
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            if (issue)  issued_q <= issued_q + 32'd1;

            if (load) begin
                if (pop) begin
                    rq_vld  <= 1'b1;
                    rq_vadr <= ld_addr;
                    rq_data <= mem[rd_ptr];
                    ld_addr <= ld_addr + 48'd8;
                end else begin
                    rq_vld  <= 1'b0;
                end
            end else if (term) begin
                rq_vld <= 1'b0;
            end

            case (state)
                S_RUN: begin
                    if (term) state <= S_DONE;
                end
                default: begin
                    if (start) begin
                        count_q  <= row_count;
                        ld_addr  <= y_base;
                        issued_q <= '0;
                        wr_ptr   <= '0;
                        rd_ptr   <= '0;
                        occ      <= '0;
                        stall_q  <= 1'b0;
                        ovf_q    <= 1'b0;
                        state    <= (row_count == '0) ? S_DONE : S_RUN;
                    end
                end
            endcase

            if (drop) ovf_q <= 1'b1;
        end
    end

    assign stall_out    = stall_q;
    assign mc_rq_vld    = rq_vld;
    assign mc_rq_cmd    = rq_vld ? WR_CMD : '0;
    assign mc_rq_vadr   = rq_vadr;
    assign mc_rq_data   = rq_data;
    assign busy         = (state == S_RUN);
    assign done         = (state == S_DONE);
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_y_result_writer.sv
// Testbench for y_result_writer: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_y_result_writer;

    logic        clk = 1'b0;
    logic        r_rst = 1'b1, r_start = 1'b0, r_push = 1'b0, r_stall = 1'b0;
    logic [47:0] r_base = '0;
    logic [31:0] r_cnt = '0;
    logic [65:0] r_v = '0;

    logic        stall_out, mc_rq_vld, busy, done, overflow_err;
    logic [2:0]  mc_rq_cmd;
    logic [47:0] mc_rq_vadr;
    logic [63:0] mc_rq_data;

    always #5 clk = ~clk;

    y_result_writer #(.FIFO_DEPTH(32), .SKID(16), .WR_CMD(3'd2)) dut (
        .clk(clk), .rst(r_rst), .start(r_start), .y_base(r_base), .row_count(r_cnt),
        .push_to_y(r_push), .v_to_y(r_v), .stall_out(stall_out),
        .mc_rq_vld(mc_rq_vld), .mc_rq_cmd(mc_rq_cmd), .mc_rq_vadr(mc_rq_vadr),
        .mc_rq_data(mc_rq_data), .mc_rq_stall(r_stall),
        .busy(busy), .done(done), .overflow_err(overflow_err)
    );

    int errs = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: 0 idle, 1 run, 2 done
    int          m_state;
    logic [63:0] m_fifo[$];
    bit          m_rv, m_ovf, m_stall;
    logic [47:0] m_addr, m_base, m_idx;
    logic [63:0] m_data;
    logic [31:0] m_issued, m_cnt;

    typedef struct { logic [47:0] a; logic [63:0] d; } req_t;
    req_t log_q[$];

    function automatic logic [63:0] ref_conv(input logic [65:0] v);
        case (v[65:64])
            2'd0:    return {v[63], 63'b0};
            2'd1:    return v[63:0];
            2'd2:    return {v[63], 11'h7FF, 52'b0};
            default: return 64'h7FF8_0000_0000_0000;
        endcase
    endfunction

    task automatic model_step();
        bit issue;
        if (r_rst) begin
            m_state = 0; m_fifo.delete(); m_rv = 0; m_addr = '0; m_data = '0;
            m_issued = '0; m_cnt = '0; m_idx = '0; m_base = '0; m_ovf = 0; m_stall = 0;
            return;
        end
        if (m_state == 1) begin
            issue = m_rv && !r_stall;
            if (issue) m_issued++;
            if (issue && m_issued == m_cnt) begin
                m_rv = 0;
                m_state = 2;
            end else if (!m_rv || issue) begin
                if (m_fifo.size() > 0) begin
                    m_rv = 1;
                    m_data = m_fifo.pop_front();
                    m_addr = m_base + (m_idx << 3);
                    m_idx++;
                end else begin
                    m_rv = 0;
                end
            end
            if (r_push) begin
                if (m_fifo.size() < 32) m_fifo.push_back(ref_conv(r_v));
                else m_ovf = 1;
            end
        end else begin
            if (r_start) begin
                m_base = r_base; m_cnt = r_cnt; m_issued = '0; m_idx = '0;
                m_fifo.delete(); m_ovf = 0;
                m_state = (r_cnt == 0) ? 2 : 1;
            end
            if (r_push) m_ovf = 1;
        end
        m_stall = (m_fifo.size() >= 16);
    endtask

    task automatic compare_all();
        check("vld", 64'(mc_rq_vld), 64'(m_rv));
        check("cmd", 64'(mc_rq_cmd), m_rv ? 64'd2 : 64'd0);
        check("busy", 64'(busy), 64'(m_state == 1));
        check("done", 64'(done), 64'(m_state == 2));
        check("ovf", 64'(overflow_err), 64'(m_ovf));
        check("stall_out", 64'(stall_out), 64'(m_stall));
        if (m_rv) begin
            check("vadr", 64'(mc_rq_vadr), 64'(m_addr));
            check("data", mc_rq_data, m_data);
        end
    endtask

    task automatic cyc();
        if (!r_rst && mc_rq_vld && !r_stall) log_q.push_back('{mc_rq_vadr, mc_rq_data});
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_start(input logic [47:0] b, input logic [31:0] c);
        r_base = b; r_cnt = c; r_start = 1'b1;
        cyc();
        r_start = 1'b0;
        log_q.delete();
    endtask

    task automatic push(input logic [65:0] v);
        r_push = 1'b1; r_v = v;
        cyc();
        r_push = 1'b0;
    endtask

    initial begin
        logic [31:0] t0, t1;
        logic [63:0] pay;

        idle(2);
        r_rst = 1'b0;
        check("rst_vld", 64'(mc_rq_vld), 64'd0);
        check("rst_outs", {mc_rq_vadr, 16'd0} | mc_rq_data | 64'(mc_rq_cmd), 64'd0);
        check("rst_flags", 64'({stall_out, busy, done, overflow_err}), 64'd0);

        // Basic run, latency
        do_start(48'h1000, 32'd3);
        push({2'b01, 64'h3FF0_0000_0000_0000});
        check("lat_t1", 64'(mc_rq_vld), 64'd0);
        push({2'b01, 64'h4000_0000_0000_0000});
        check("lat_t2", 64'(mc_rq_vld), 64'd1);
        push({2'b01, 64'hC008_0000_0000_0000});
        idle(5);
        check("t1_n", 64'(log_q.size()), 64'd3);
        if (log_q.size() == 3) begin
            check("t1_a0", 64'(log_q[0].a), 64'h1000);
            check("t1_a1", 64'(log_q[1].a), 64'h1008);
            check("t1_a2", 64'(log_q[2].a), 64'h1010);
            check("t1_d0", log_q[0].d, 64'h3FF0_0000_0000_0000);
            check("t1_d1", log_q[1].d, 64'h4000_0000_0000_0000);
            check("t1_d2", log_q[2].d, 64'hC008_0000_0000_0000);
        end
        check("t1_done", 64'(done), 64'd1);

        // Exception conversion
        do_start(48'h2000, 32'd3);
        push({2'b00, 1'b1, 63'h1234_5678});
        push({2'b10, 1'b0, 63'h55AA});
        pay = {$urandom, $urandom};
        push({2'b11, pay});
        idle(5);
        check("t2_n", 64'(log_q.size()), 64'd3);
        if (log_q.size() == 3) begin
            check("t2_d0", log_q[0].d, 64'h8000_0000_0000_0000);
            check("t2_d1", log_q[1].d, 64'h7FF0_0000_0000_0000);
            check("t2_d2", log_q[2].d, 64'h7FF8_0000_0000_0000);
        end

        // Backpressure
        do_start(48'h3000, 32'd20);
        r_stall = 1'b1;
        for (int i = 0; i < 20; i++) push({2'b01, 64'(i) + 64'h100});
        idle(3);
        check("t3_stall_hi", 64'(stall_out), 64'd1);
        r_stall = 1'b0;
        idle(30);
        check("t3_n", 64'(log_q.size()), 64'd20);
        for (int i = 0; i < log_q.size(); i++)
            check("t3_addr", 64'(log_q[i].a), 64'h3000 + 64'(8 * i));
        check("t3_stall_lo", 64'(stall_out), 64'd0);

        // Overflow
        do_start(48'h4000, 32'd33);
        r_stall = 1'b1;
        for (int i = 0; i < 34; i++) push({2'b01, 64'(i)});
        check("t4_ovf", 64'(overflow_err), 64'd1);
        r_stall = 1'b0;
        idle(40);
        check("t4_n", 64'(log_q.size()), 64'd33);
        do_start(48'h0, 32'd0);
        check("t4_ovf_clr", 64'(overflow_err), 64'd0);
        check("t5_done0", 64'(done), 64'd1);
        check("t5_noreq", 64'(mc_rq_vld), 64'd0);

        // Reset mid-run
        do_start(48'h5000, 32'd10);
        r_stall = 1'b1;
        for (int i = 0; i < 5; i++) push({2'b01, 64'(i)});
        r_rst = 1'b1;
        cyc();
        r_rst = 1'b0; r_stall = 1'b0;
        check("t5_rst", 64'({mc_rq_vld, stall_out, busy, done, overflow_err, mc_rq_cmd}), 64'd0);
        check("t5_rst_ad", 64'(mc_rq_vadr) | mc_rq_data, 64'd0);
        cyc();
        check("t5_idle", 64'(mc_rq_vld), 64'd0);

        // Address wrap
        do_start(48'hFFFF_FFFF_FFF8, 32'd2);
        push({2'b01, 64'hAAAA});
        push({2'b01, 64'hBBBB});
        idle(4);
        check("t6_n", 64'(log_q.size()), 64'd2);
        if (log_q.size() == 2) begin
            check("t6_a0", 64'(log_q[0].a), 64'hFFFF_FFFF_FFF8);
            check("t6_a1", 64'(log_q[1].a), 64'h0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            t0 = $urandom; t1 = $urandom;
            r_start = ($urandom_range(0, 39) == 0);
            r_cnt   = 32'($urandom_range(0, 40));
            r_base  = {t0[15:0], t1[31:3], 3'b000};
            r_push  = stall_out ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 6);
            t0 = $urandom; t1 = $urandom;
            r_v     = {t0[1:0], t1, 32'($urandom)};
            r_stall = ($urandom_range(0, 9) < 3);
            cyc();
        end
        r_start = 1'b0; r_push = 1'b0; r_stall = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
